// File: rtl/dm_cmd_seq_pkg.sv
// Shared definitions for the DataMover command sequencer.
// Holds the sequencer FSM state type, the bit positions of the fields in
// the 72-bit DataMover command and the 8-bit DataMover status, and the
// command/BTT widths used by dm_cmd_seq and dm_cmd_pack.
package dm_cmd_seq_pkg;

    localparam int CMD_W = 72;
    localparam int BTT_W = 23;

    // Command word field positions
    localparam int CMD_TAG_LSB   = 64;
    localparam int CMD_TAG_W     = 4;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_SADDR_W   = 32;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_INCR_BIT  = 23;

    // Status byte field positions
    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_TAG_LSB    = 0;
    localparam int STS_TAG_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/dm_cmd_pack.sv
// Combinational assembly of one DataMover command word.
// Ports:
//   tag   in  4       command tag
//   saddr in  32      start byte address
//   eof   in  1       end-of-frame flag
//   btt   in  BTT_W   bytes to transfer
//   cmd   out CMD_W   packed command (INCR burst type, reserved bits zero)
module dm_cmd_pack
    import dm_cmd_seq_pkg::*;
(
    input  logic [CMD_TAG_W-1:0]   tag,
    input  logic [CMD_SADDR_W-1:0] saddr,
    input  logic                   eof,
    input  logic [BTT_W-1:0]       btt,
    output logic [CMD_W-1:0]       cmd
);

    // Start from all-zero so every reserved field stays 0, then drop each
    // field into place.
    always_comb begin
        cmd = '0;
        cmd[CMD_TAG_LSB +: CMD_TAG_W]     = tag;
        cmd[CMD_SADDR_LSB +: CMD_SADDR_W] = saddr;
        cmd[CMD_EOF_BIT]                  = eof;
        cmd[CMD_INCR_BIT]                 = 1'b1;
        cmd[BTT_W-1:0]                    = btt;
    end

endmodule

// File: rtl/dm_cmd_seq.sv
// DataMover command sequencer: splits one job (base address, total length)
// into chunk_len-sized DataMover commands, limits the number of commands in
// flight, checks the returned status beats and reports completion.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    one-cycle job launch (accepted only in IDLE)
//   base_addr/total_len      job byte address and byte length
//   chunk_len                maximum BTT per command
//   eof_all                  1: EOF on every command, 0: on the last only
//   busy/done/err/err_sts    job status, done is a one-cycle pulse
//   cmd_cnt                  commands accepted in the current job
//   m_axis_cmd_*             DataMover command stream
//   s_axis_sts_*             DataMover status stream (always ready)
module dm_cmd_seq
    import dm_cmd_seq_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [31:0]      total_len,
    input  logic [22:0]      chunk_len,
    input  logic             eof_all,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_sts,
    output logic [15:0]      cmd_cnt,
    output logic [CMD_W-1:0] m_axis_cmd_tdata,
    output logic             m_axis_cmd_tvalid,
    input  logic             m_axis_cmd_tready,
    input  logic [7:0]       s_axis_sts_tdata,
    input  logic             s_axis_sts_tvalid,
    output logic             s_axis_sts_tready
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t            state_q, state_d;
    logic [31:0]       rem_q, rem_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        tag_q, tag_d;
    logic [3:0]        exp_tag_q, exp_tag_d;
    logic [BTT_W-1:0]  chunk_q, chunk_d;
    logic              eof_all_q, eof_all_d;
    logic [3:0]        out_q, out_d;
    logic              err_q, err_d;
    logic [7:0]        err_sts_q, err_sts_d;
    logic [15:0]       cmd_cnt_q, cmd_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tvalid_q, tvalid_d;
    logic [CMD_W-1:0]  tdata_q, tdata_d;

    logic              cmd_hs;
    logic              sts_hs;
    logic              sts_fail;
    logic              sts_dec;
    logic [31:0]       cur_btt;
    logic [31:0]       chunk_ext;
    logic [BTT_W-1:0]  next_btt;
    logic              next_eof;
    logic [CMD_W-1:0]  next_cmd;

    assign s_axis_sts_tready = 1'b1;
    assign cmd_hs  = tvalid_q && m_axis_cmd_tready;
    assign sts_hs  = s_axis_sts_tvalid;
    assign cur_btt = {{(32-BTT_W){1'b0}}, tdata_q[BTT_W-1:0]};

    // A status beat is bad if OKAY is clear, any error bit is set, or it
    // completes a command other than the oldest one still in flight.
    assign sts_fail = !s_axis_sts_tdata[STS_OKAY_BIT]
                   || s_axis_sts_tdata[STS_SLVERR_BIT]
                   || s_axis_sts_tdata[STS_DECERR_BIT]
                   || s_axis_sts_tdata[STS_INTERR_BIT]
                   || (s_axis_sts_tdata[STS_TAG_LSB +: STS_TAG_W] != exp_tag_q);
    assign sts_dec  = sts_hs && (out_q != 4'd0);

    // Job bookkeeping and state transitions. A start with nothing to issue
    // (zero length or zero chunk) goes straight to DRAIN so done follows two
    // cycles after start. ISSUE only leaves once the command currently on
    // the bus has been accepted, so a late error never truncates a beat.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        tag_d     = tag_q;
        exp_tag_d = exp_tag_q;
        chunk_d   = chunk_q;
        eof_all_d = eof_all_q;
        out_d     = out_q;
        err_d     = err_q;
        err_sts_d = err_sts_q;
        cmd_cnt_d = cmd_cnt_q;

        if (state_q != ST_IDLE) begin
            if (cmd_hs) begin
                rem_d     = rem_q - cur_btt;
                addr_d    = addr_q + cur_btt;
                tag_d     = tag_q + 4'd1;
                cmd_cnt_d = cmd_cnt_q + 16'd1;
            end
            if (sts_hs) begin
                if (out_q == 4'd0) begin
                    err_d = 1'b1;
                end else begin
                    exp_tag_d = exp_tag_q + 4'd1;
                    if (sts_fail && !err_q) begin
                        err_d     = 1'b1;
                        err_sts_d = s_axis_sts_tdata;
                    end
                end
            end
            case ({cmd_hs, sts_dec})
                2'b10:   out_d = out_q + 4'd1;
                2'b01:   out_d = out_q - 4'd1;
                default: out_d = out_q;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d     = total_len;
                    addr_d    = base_addr;
                    chunk_d   = chunk_len;
                    eof_all_d = eof_all;
                    tag_d     = 4'd0;
                    exp_tag_d = 4'd0;
                    out_d     = 4'd0;
                    cmd_cnt_d = 16'd0;
                    err_sts_d = 8'd0;
                    err_d     = (total_len != 32'd0) && (chunk_len == '0);
                    state_d   = ((total_len == 32'd0) || (chunk_len == '0))
                              ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (((rem_d == 32'd0) || err_d) && !(tvalid_q && !cmd_hs))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_q == 4'd0)
                    state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fields of the next command, taken from the post-handshake bookkeeping
    // so a new command can be presented right behind an accepted one.
    always_comb begin
        chunk_ext = {{(32-BTT_W){1'b0}}, chunk_d};
        next_btt  = (rem_d < chunk_ext) ? rem_d[BTT_W-1:0] : chunk_d;
        next_eof  = eof_all_d || (rem_d <= chunk_ext);
    end

    dm_cmd_pack u_pack (
        .tag   (tag_d),
        .saddr (addr_d),
        .eof   (next_eof),
        .btt   (next_btt),
        .cmd   (next_cmd)
    );

    // Command stream register: a presented command is held until accepted;
    // a new one is loaded only when the bus is free (or being freed) and
    // there is work, credit and no error.
    always_comb begin
        tvalid_d = tvalid_q && !cmd_hs;
        tdata_d  = tdata_q;
        if ((rem_d != 32'd0) && (out_d < MAX_OUT) && !err_d &&
            ((state_q == ST_IDLE && start && chunk_len != '0) ||
             (state_q == ST_ISSUE && (!tvalid_q || cmd_hs)))) begin
            tvalid_d = 1'b1;
            tdata_d  = next_cmd;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            addr_q    <= '0;
            tag_q     <= '0;
            exp_tag_q <= '0;
            chunk_q   <= '0;
            eof_all_q <= 1'b0;
            out_q     <= '0;
            err_q     <= 1'b0;
            err_sts_q <= '0;
            cmd_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            exp_tag_q <= exp_tag_d;
            chunk_q   <= chunk_d;
            eof_all_q <= eof_all_d;
            out_q     <= out_d;
            err_q     <= err_d;
            err_sts_q <= err_sts_d;
            cmd_cnt_q <= cmd_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign err_sts           = err_sts_q;
    assign cmd_cnt           = cmd_cnt_q;
    assign m_axis_cmd_tvalid = tvalid_q;
    assign m_axis_cmd_tdata  = tdata_q;

endmodule
